// File: rtl/rr_stage_pkg.sv
// rr_stage_pkg: shared constants and types for the register-read stage.
// Holds MIPS field positions, default widths, the control-bundle type and
// its all-zero bubble value, plus a sign-extension helper.
package rr_stage_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int INSTR_W = 32;

    // MIPS instruction field positions
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Control bundle carried from ID/RR into RR/EX
    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic       jump;
        logic       ctrl_r;
        logic [3:0] alu_control;
    } ctrl_t;

    // A bubble carries no side effects: every control bit cleared
    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic logic [INSTR_W-1:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/rr_stage_reg_file.sv
// rr_stage_reg_file: 2-read / 1-write register file with asynchronous
// active-low reset. Register 0 is hard-wired to zero and a write in flight
// is bypassed to a matching read address in the same cycle.
module rr_stage_reg_file #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [1:0][REG_AW-1:0]      rd_addr_i,
    output logic [1:0][DATA_W-1:0]      rd_data_o,
    input  logic                        wr_en_i,
    input  logic [REG_AW-1:0]           wr_addr_i,
    input  logic [DATA_W-1:0]           wr_data_i
);

    localparam int NREGS = 2 ** REG_AW;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              wr_valid;

    // Writes to r0 are discarded so it never holds a nonzero value
    assign wr_valid = wr_en_i && (wr_addr_i != '0);

    // Register storage: cleared on reset, written on valid writeback
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_valid) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd_port
            // Read port: r0 reads zero, in-flight write wins over stored value
            always_comb begin
                rd_data_o[gi] = regs_q[rd_addr_i[gi]];
                if (rd_addr_i[gi] == '0) begin
                    rd_data_o[gi] = '0;
                end else if (wr_valid && (wr_addr_i == rd_addr_i[gi])) begin
                    rd_data_o[gi] = wr_data_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/rr_stage.sv
// rr_stage: register-read pipeline stage. Decodes register fields, reads the
// register file (with writeback bypass), detects load-use hazards against the
// instruction in EX and registers everything into the RR/EX pipeline register.
// Optional feature macro: RR_STALL_CNT_EN adds a 32-bit hazard stall counter
// on output stall_cnt_o.
module rr_stage #(
    parameter int DATA_W = rr_stage_pkg::DATA_W,
    parameter int REG_AW = rr_stage_pkg::REG_AW
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [31:0]         instr_i,
    input  logic [31:0]         pc_i,
    input  logic                regwrite_i,
    input  logic                memread_i,
    input  logic                memwrite_i,
    input  logic                memtoreg_i,
    input  logic                alusrc_i,
    input  logic                branch_i,
    input  logic                jump_i,
    input  logic                ctrl_r_i,
    input  logic [3:0]          alu_control_i,
    input  logic                wb_we_i,
    input  logic [REG_AW-1:0]   wb_addr_i,
    input  logic [DATA_W-1:0]   wb_data_i,
    input  logic                rr_ex_lock_i,
    input  logic                rr_ex_flush_i,
    output logic                id_rr_lock_o,
    output logic [DATA_W-1:0]   rs_data_o,
    output logic [DATA_W-1:0]   rt_data_o,
    output logic [31:0]         imm_o,
    output logic [REG_AW-1:0]   rs_o,
    output logic [REG_AW-1:0]   rt_o,
    output logic [REG_AW-1:0]   dst_o,
    output logic [31:0]         pc_o,
    output logic [31:0]         instr_o,
    output logic                regwrite_o,
    output logic                memread_o,
    output logic                memwrite_o,
    output logic                memtoreg_o,
    output logic                alusrc_o,
    output logic                branch_o,
    output logic                jump_o,
    output logic                ctrl_r_o,
    output logic [3:0]          alu_control_o
`ifdef RR_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt_o
`endif
);

    import rr_stage_pkg::*;

    // Decoded fields of the instruction sitting in ID/RR
    logic [REG_AW-1:0]         rs;
    logic [REG_AW-1:0]         rt;
    logic [REG_AW-1:0]         rd;
    logic [REG_AW-1:0]         dst;
    logic [31:0]               imm;
    logic [1:0][REG_AW-1:0]    rd_addr;
    logic [1:0][DATA_W-1:0]    rd_data;
    ctrl_t                     ctrl_in;
    logic                      uses_rt;
    logic                      hazard;

    // RR/EX pipeline register
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [31:0]       imm_q, imm_d;
    logic [REG_AW-1:0] rs_q, rs_d;
    logic [REG_AW-1:0] rt_q, rt_d;
    logic [REG_AW-1:0] dst_q, dst_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    ctrl_t             ctrl_q, ctrl_d;

    assign rs  = instr_i[RS_MSB:RS_LSB];
    assign rt  = instr_i[RT_MSB:RT_LSB];
    assign rd  = instr_i[RD_MSB:RD_LSB];
    assign dst = ctrl_r_i ? rd : rt;
    assign imm = sign_ext16(instr_i[IMM_MSB:IMM_LSB]);

    assign ctrl_in.regwrite    = regwrite_i;
    assign ctrl_in.memread     = memread_i;
    assign ctrl_in.memwrite    = memwrite_i;
    assign ctrl_in.memtoreg    = memtoreg_i;
    assign ctrl_in.alusrc      = alusrc_i;
    assign ctrl_in.branch      = branch_i;
    assign ctrl_in.jump        = jump_i;
    assign ctrl_in.ctrl_r      = ctrl_r_i;
    assign ctrl_in.alu_control = alu_control_i;

    assign rd_addr[0] = rs;
    assign rd_addr[1] = rt;

    rr_stage_reg_file #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_reg_file (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .wr_en_i   (wb_we_i),
        .wr_addr_i (wb_addr_i),
        .wr_data_i (wb_data_i)
    );

    // rt is a true source only for R-type, stores and branches
    assign uses_rt = ctrl_r_i | memwrite_i | branch_i;
    assign hazard  = ctrl_q.memread && (dst_q != '0) &&
                     ((dst_q == rs) || ((dst_q == rt) && uses_rt));

    // A flush squashes whatever would have stalled, so it also drops the stall
    assign id_rr_lock_o = (hazard | rr_ex_lock_i) & ~rr_ex_flush_i;

    // RR/EX next state: flush, then hold on lock, then bubble on hazard, else load
    always_comb begin
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        dst_d     = dst_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        ctrl_d    = ctrl_q;
        if (rr_ex_flush_i || (!rr_ex_lock_i && hazard)) begin
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            rs_d      = '0;
            rt_d      = '0;
            dst_d     = '0;
            pc_d      = '0;
            instr_d   = '0;
            ctrl_d    = CTRL_BUBBLE;
        end else if (!rr_ex_lock_i) begin
            rs_data_d = rd_data[0];
            rt_data_d = rd_data[1];
            imm_d     = imm;
            rs_d      = rs;
            rt_d      = rt;
            dst_d     = dst;
            pc_d      = pc_i;
            instr_d   = instr_i;
            ctrl_d    = ctrl_in;
        end
    end

    // RR/EX register update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dst_q     <= '0;
            pc_q      <= '0;
            instr_q   <= '0;
            ctrl_q    <= CTRL_BUBBLE;
        end else begin
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            dst_q     <= dst_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign rs_data_o     = rs_data_q;
    assign rt_data_o     = rt_data_q;
    assign imm_o         = imm_q;
    assign rs_o          = rs_q;
    assign rt_o          = rt_q;
    assign dst_o         = dst_q;
    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign regwrite_o    = ctrl_q.regwrite;
    assign memread_o     = ctrl_q.memread;
    assign memwrite_o    = ctrl_q.memwrite;
    assign memtoreg_o    = ctrl_q.memtoreg;
    assign alusrc_o      = ctrl_q.alusrc;
    assign branch_o      = ctrl_q.branch;
    assign jump_o        = ctrl_q.jump;
    assign ctrl_r_o      = ctrl_q.ctrl_r;
    assign alu_control_o = ctrl_q.alu_control;

`ifdef RR_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Hazard cycles that are not squashed by a flush count as stalls; wraps naturally
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !rr_ex_flush_i) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/rr_stage.md
Name: rr_stage

Overview:
Register-read stage that consumes the decoded instruction and control bundle held by the ID/RR pipeline latch. It contains the 32x32 register file with a writeback port and a same-cycle write-through bypass. It detects load-use hazards against the instruction currently in EX and drives the stall back to the ID/RR latch. Results are registered into the RR/EX pipeline register, which feeds the execute stage.

Parameters:
DATA_W, 32, register and datapath width
REG_AW, 5, register address width (2**REG_AW registers)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_ni  in  1  asynchronous active-low reset
instr_i  in  32  instruction from ID/RR latch, MIPS format
pc_i  in  32  PC from ID/RR latch
regwrite_i, memread_i, memwrite_i, memtoreg_i, alusrc_i, branch_i, jump_i, ctrl_r_i  in  1 each  control from ID/RR latch
alu_control_i  in  4  ALU op from ID/RR latch
wb_we_i  in  1  writeback enable
wb_addr_i  in  REG_AW  writeback register
wb_data_i  in  DATA_W  writeback data
rr_ex_lock_i  in  1  hold RR/EX register (EX busy)
rr_ex_flush_i  in  1  squash RR/EX contents (taken branch/jump)
id_rr_lock_o  out  1  stall request to ID/RR latch (combinational)
rs_data_o, rt_data_o  out  DATA_W  registered operands
imm_o  out  32  registered sign-extended instr[15:0]
rs_o, rt_o, dst_o  out  REG_AW  registered source/destination indices
pc_o, instr_o  out  32  registered pass-through
regwrite_o, memread_o, memwrite_o, memtoreg_o, alusrc_o, branch_o, jump_o, ctrl_r_o  out  1 each  registered control
alu_control_o  out  4  registered ALU op

Behaviour:
- Field decode: rs=instr[25:21], rt=instr[20:16], rd=instr[15:11]; dst = ctrl_r_i ? rd : rt.
- Register file: reset clears all registers to 0. Writes occur on the rising edge when wb_we_i=1 and wb_addr_i!=0. Register 0 always reads 0.
- Bypass: if wb_we_i=1, wb_addr_i!=0 and wb_addr_i equals the read address, the read returns wb_data_i in the same cycle.
- Load-use hazard: asserted when memread_o=1, dst_o!=0, and either:
  - dst_o==rs, or
  - dst_o==rt with the current instruction using rt (ctrl_r_i | memwrite_i | branch_i).
- id_rr_lock_o = (hazard | rr_ex_lock_i) & !rr_ex_flush_i.
- RR/EX update priority:
  1. reset: all outputs 0.
  2. rr_ex_flush_i: all outputs 0.
  3. rr_ex_lock_i: hold all outputs.
  4. hazard: bubble, all outputs 0.
  5. otherwise: load decoded values.
- Latency: 1 cycle from ID/RR to RR/EX. A load-use costs exactly one bubble; on the next cycle memread_o=0, so the hazard clears.
- Writeback is independent of lock, flush and hazard.
- Reset mid-operation clears the register file and RR/EX immediately; no pending writeback survives.

Optional Feature:
RR_STALL_CNT_EN:
- Defined: adds output stall_cnt_o (32 bits), reset to 0. It increments by 1 on each cycle in which hazard=1 and rr_ex_flush_i=0, and wraps 0xFFFFFFFF->0.
- Undefined: the port and counter do not exist; no other behaviour changes.

Decomposition:
- Shared package: field bit positions (RS_MSB/LSB, RT_*, RD_*, IMM_*), REG_AW, DATA_W, and the all-zero bubble constants for the control bundle.
- Sub-module: reg_file (2 read ports, 1 write port, bypass, reg0=0). Hazard logic and the RR/EX register stay in rr_stage.

Test Plan:
- Reset, then read r1..r31 -> rs_data_o/rt_data_o all 0; all outputs 0 while rst_ni=0.
- Write r5=0xDEADBEEF with instr reading rs=5 in the same cycle -> next edge rs_data_o=0xDEADBEEF (bypass).
- wb_we_i=1, wb_addr_i=0, data 0x1234 -> later read of r0 returns 0.
- Load lw dst=8 in RR/EX (memread_o=1), followed by an R-type with rt=8 -> id_rr_lock_o=1 for one cycle, one all-zero bubble, then the R-type issues; counter=1 if RR_STALL_CNT_EN.
- rr_ex_flush_i together with a hazard -> outputs 0, id_rr_lock_o=0, counter unchanged.
- rr_ex_lock_i held 3 cycles -> outputs frozen, id_rr_lock_o=1 for 3 cycles, writebacks still land in the register file.
